// File: rtl/silife_max7219.sv
// silife_max7219
// Refreshes a 4x4 daisy chain of MAX7219 8x8 LED drivers that together show a
// 32x32 cell grid. One frame is 13 SPI transactions: four configuration
// transactions, one intensity transaction, then eight digit transactions that
// carry the grid rows. Each transaction shifts one 16-bit word per device,
// device 15 first, MSB first, in SPI mode 0 at clk/2.
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous active-high reset
//   i_cells[31:0]     cells of grid row o_row_select (bit n = column n),
//                     combinational from o_row_select
//   i_enable          refresh permitted
//   i_brightness[3:0] MAX7219 intensity value
//   i_reverse_columns mirror bit order inside each 8-column byte
//   i_serpentine      odd module rows are wired right-to-left
//   i_frame           frame-start request
//   o_cs              SPI chip select, active low
//   o_sck             SPI clock
//   o_mosi            SPI data
//   o_busy            frame in progress
//   o_row_select[4:0] registered grid row index for i_cells
//
// Handshake: a frame request is accepted on a rising edge where the FSM is in
// IDLE and i_enable && i_frame are both 1. o_busy goes high the following cycle
// and stays high until IDLE is re-entered; requests while busy are ignored.
module silife_max7219 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_cells,
    input  logic        i_enable,
    input  logic [3:0]  i_brightness,
    input  logic        i_reverse_columns,
    input  logic        i_serpentine,
    input  logic        i_frame,
    output logic        o_cs,
    output logic        o_sck,
    output logic        o_mosi,
    output logic        o_busy,
    output logic [4:0]  o_row_select
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t      state, state_n;
    logic        phase, phase_n;        // 0: sck low half, 1: sck high half
    logic [3:0]  bit_cnt, bit_cnt_n;    // bit within the current word
    logic [3:0]  dev, dev_n;            // device whose word is in the shifter
    logic [3:0]  txn, txn_n;            // transaction index 0..12
    logic        gap_cnt, gap_cnt_n;    // two cycles of cs high between transactions
    logic [15:0] shreg, shreg_n;
    logic [4:0]  row, row_n;

    // Word for transaction t, device d. Digit data comes from i_cells, which
    // must already reflect the row for (t, d) when this is evaluated.
    function automatic logic [15:0] make_word(
        input logic [3:0]  t,
        input logic [3:0]  d,
        input logic [31:0] cells,
        input logic [3:0]  br,
        input logic        rev,
        input logic        serp
    );
        logic [1:0] c;
        logic [7:0] raw;
        logic [7:0] b;
        logic [3:0] k;
        // d[3:2] is the module row, d[1:0] the chain column; 3-mc == ~mc.
        c   = (serp && d[2]) ? ~d[1:0] : d[1:0];
        raw = cells[{c, 3'b000} +: 8];
        for (int j = 0; j < 8; j++) begin
            b[j] = rev ? raw[7-j] : raw[j];
        end
        k = t - 4'd4;
        case (t)
            4'd0:    make_word = 16'h0C01;
            4'd1:    make_word = 16'h0B07;
            4'd2:    make_word = 16'h0900;
            4'd3:    make_word = 16'h0F00;
            4'd4:    make_word = {8'h0A, 4'h0, br};
            default: make_word = {4'h0, k, b};
        endcase
    endfunction

    // Grid row needed by device d in transaction t (digit k = t-4 shows row
    // module_row*8 + k-1). Configuration transactions do not use the grid.
    function automatic logic [4:0] row_for(input logic [3:0] t, input logic [3:0] d);
        logic [3:0] km1;
        km1 = t - 4'd5;
        row_for = (t >= 4'd5) ? {d[3:2], km1[2:0]} : 5'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= 1'b0;
            bit_cnt <= 4'd0;
            dev     <= 4'd0;
            txn     <= 4'd0;
            gap_cnt <= 1'b0;
            shreg   <= 16'd0;
            row     <= 5'd0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_cnt_n;
            dev     <= dev_n;
            txn     <= txn_n;
            gap_cnt <= gap_cnt_n;
            shreg   <= shreg_n;
            row     <= row_n;
        end
    end

    // The row for the next word is always set when the current word is
    // loaded, so i_cells has settled long before it is sampled.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_cnt_n = bit_cnt;
        dev_n     = dev;
        txn_n     = txn;
        gap_cnt_n = gap_cnt;
        shreg_n   = shreg;
        row_n     = row;
        case (state)
            IDLE: begin
                phase_n   = 1'b0;
                bit_cnt_n = 4'd0;
                gap_cnt_n = 1'b0;
                if (i_enable && i_frame) begin
                    state_n = LOAD;
                    txn_n   = 4'd0;
                    dev_n   = 4'd15;
                    row_n   = row_for(4'd0, 4'd15);
                end
            end
            LOAD: begin
                shreg_n   = make_word(txn, dev, i_cells, i_brightness,
                                      i_reverse_columns, i_serpentine);
                row_n     = row_for(txn, dev - 4'd1);
                phase_n   = 1'b0;
                bit_cnt_n = 4'd0;
                state_n   = SHIFT;
            end
            SHIFT: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n   = 1'b0;
                    bit_cnt_n = bit_cnt + 4'd1;
                    shreg_n   = {shreg[14:0], 1'b0};
                    if (bit_cnt == 4'd15) begin
                        if (dev == 4'd0) begin
                            state_n   = GAP;
                            gap_cnt_n = 1'b0;
                            row_n     = row_for(txn + 4'd1, 4'd15);
                        end else begin
                            dev_n   = dev - 4'd1;
                            shreg_n = make_word(txn, dev - 4'd1, i_cells, i_brightness,
                                                i_reverse_columns, i_serpentine);
                            row_n   = row_for(txn, dev - 4'd2);
                        end
                    end
                end
            end
            GAP: begin
                if (!gap_cnt) begin
                    gap_cnt_n = 1'b1;
                end else if (txn == 4'd12 || !i_enable) begin
                    state_n = IDLE;
                end else begin
                    state_n   = SHIFT;
                    txn_n     = txn + 4'd1;
                    dev_n     = 4'd15;
                    phase_n   = 1'b0;
                    bit_cnt_n = 4'd0;
                    shreg_n   = make_word(txn + 4'd1, 4'd15, i_cells, i_brightness,
                                          i_reverse_columns, i_serpentine);
                    row_n     = row_for(txn + 4'd1, 4'd14);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_cs         = (state != SHIFT);
    assign o_sck        = (state == SHIFT) && phase;
    assign o_mosi       = (state == SHIFT) && shreg[15];
    assign o_busy       = (state != IDLE);
    assign o_row_select = row;

endmodule

// File: tb/tb_silife_max7219.sv
// Bench for silife_max7219: randomized frames against a reference model of
// the display word format, with an SPI monitor feeding a scoreboard.
module tb_silife_max7219;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_cells;
    logic        i_enable;
    logic [3:0]  i_brightness;
    logic        i_reverse_columns;
    logic        i_serpentine;
    logic        i_frame;
    logic        o_cs;
    logic        o_sck;
    logic        o_mosi;
    logic        o_busy;
    logic [4:0]  o_row_select;

    logic [31:0] grid [32];
    assign i_cells = grid[o_row_select];

    silife_max7219 dut (
        .clk              (clk),
        .reset            (reset),
        .i_cells          (i_cells),
        .i_enable         (i_enable),
        .i_brightness     (i_brightness),
        .i_reverse_columns(i_reverse_columns),
        .i_serpentine     (i_serpentine),
        .i_frame          (i_frame),
        .o_cs             (o_cs),
        .o_sck            (o_sck),
        .o_mosi           (o_mosi),
        .o_busy           (o_busy),
        .o_row_select     (o_row_select)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q [$];
    logic [15:0] cap_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word is computed directly from the display geometry.
    function automatic logic [15:0] ref_word(input int t, input int d);
        int mr, mc, c, k;
        logic [31:0] cells;
        logic [7:0] b;
        logic [3:0] k4;
        logic [3:0] br;
        br = i_brightness;
        case (t)
            0: return 16'h0C01;
            1: return 16'h0B07;
            2: return 16'h0900;
            3: return 16'h0F00;
            4: return {8'h0A, 4'h0, br};
            default: ;
        endcase
        mr = d / 4;
        mc = d % 4;
        c  = (i_serpentine && (mr % 2 == 1)) ? 3 - mc : mc;
        k  = t - 4;
        cells = grid[mr * 8 + k - 1];
        for (int j = 0; j < 8; j++) begin
            b[j] = i_reverse_columns ? cells[c * 8 + 7 - j] : cells[c * 8 + j];
        end
        k4 = k[3:0];
        return {4'h0, k4, b};
    endfunction

    task automatic push_frame();
        for (int t = 0; t < 13; t++) begin
            for (int d = 15; d >= 0; d--) begin
                exp_q.push_back(ref_word(t, d));
            end
        end
    endtask

    // ---------------- monitor ----------------
    int          mon_bits = 0;
    logic [15:0] mon_word = 16'd0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_mosi = 1'b0;
    int          high_run = 0;
    logic        busy_low_seen = 1'b1;

    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            mon_bits      = 0;
            mon_word      = 16'd0;
            prev_sck      = 1'b0;
            prev_cs       = 1'b1;
            high_run      = 0;
            busy_low_seen = 1'b1;
        end else begin
            if (!o_busy) begin
                check("idle_cs", o_cs, 1);
                check("idle_sck", o_sck, 0);
                check("idle_mosi", o_mosi, 0);
            end
            if (!o_cs) begin
                if (prev_cs) begin
                    if (!busy_low_seen) check("gap_len", high_run, 2);
                end
                if (o_sck && !prev_sck) begin
                    check("mosi_stable", o_mosi, prev_mosi);
                    mon_word = {mon_word[14:0], o_mosi};
                    mon_bits++;
                    if (mon_bits % 16 == 0) begin
                        cap_q.push_back(mon_word);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL word_unexpected: got %h, expected none", mon_word);
                        end else begin
                            e = exp_q.pop_front();
                            check("word", mon_word, e);
                        end
                    end
                end
            end else begin
                check("cs_high_sck", o_sck, 0);
                if (!prev_cs) begin
                    check("sck_edges_per_cs", mon_bits, 256);
                    mon_bits      = 0;
                    high_run      = 0;
                    busy_low_seen = 1'b0;
                end
                high_run++;
                if (!o_busy) busy_low_seen = 1'b1;
            end
            prev_sck  = o_sck;
            prev_cs   = o_cs;
            prev_mosi = o_mosi;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic randomize_settings();
        for (int r = 0; r < 32; r++) grid[r] = $urandom();
        i_brightness      = 4'($urandom_range(0, 15));
        i_reverse_columns = 1'($urandom_range(0, 1));
        i_serpentine      = 1'($urandom_range(0, 1));
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1;
        push_frame();
        i_frame = 1'b1;
        @(posedge clk);
        #1;
        i_frame = 1'b0;
        @(negedge clk);
        check("busy_after_start", o_busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_in_time", (n < budget), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int falls;
        logic pc;
        reset             = 1'b1;
        i_enable          = 1'b0;
        i_frame           = 1'b0;
        i_brightness      = 4'h0;
        i_reverse_columns = 1'b0;
        i_serpentine      = 1'b0;
        for (int r = 0; r < 32; r++) grid[r] = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset with enable low.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("rst_cs", o_cs, 1);
            check("rst_busy", o_busy, 0);
            check("rst_row", o_row_select, 0);
        end

        // Directed frame with known row contents.
        grid[0]           = 32'h0000_0020;
        grid[4]           = 32'h5444_3424;
        grid[12]          = 32'h5545_3525;
        i_brightness      = 4'hF;
        i_reverse_columns = 1'b1;
        i_serpentine      = 1'b1;
        i_enable          = 1'b1;
        cap_q.delete();
        start_frame();
        wait_idle(8000);
        check("dir_queue_empty", exp_q.size(), 0);
        check("dir_word_count", cap_q.size(), 208);
        if (cap_q.size() == 208) begin
            check("dir_first_word", cap_q[0], 16'h0C01);
            check("dir_intensity", cap_q[64], 16'h0A0F);
            check("dir_digit1_dev0", cap_q[95], 16'h0104);
            check("dir_digit5_dev1", cap_q[158], 16'h052C);
            check("dir_digit5_dev4", cap_q[155], 16'h05AA);
        end
        repeat (5) @(negedge clk);

        // Random single frames.
        for (int f = 0; f < 2; f++) begin
            randomize_settings();
            start_frame();
            wait_idle(8000);
            check("rnd_queue_empty", exp_q.size(), 0);
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end

        // Back-to-back frames with frame held high.
        randomize_settings();
        @(posedge clk);
        #1;
        push_frame();
        push_frame();
        push_frame();
        i_frame = 1'b1;
        n = 0;
        while (!o_busy && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("cont_start", o_busy, 1);
        for (int f = 0; f < 3; f++) begin
            if (f == 2) i_frame = 1'b0;
            n = 0;
            while (o_busy && n < 7000) begin
                @(negedge clk);
                n++;
            end
            check("cont_busy_len", n, 6683);
            if (f < 2) begin
                n = 0;
                while (!o_busy && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                check("cont_idle_gap", n, 1);
            end
        end
        repeat (4) @(negedge clk);
        check("cont_queue_empty", exp_q.size(), 0);

        // Enable dropped during transaction 2.
        randomize_settings();
        cap_q.delete();
        start_frame();
        falls = 0;
        pc    = o_cs;
        n     = 0;
        while (falls < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (pc && !o_cs) falls++;
            pc = o_cs;
        end
        check("drop_reached_txn2", falls, 3);
        i_enable = 1'b0;
        wait_idle(1000);
        check("drop_words_sent", cap_q.size(), 48);
        check("drop_words_left", exp_q.size(), 160);
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("drop_stays_idle", o_busy, 0);

        // Reset in the middle of a digit transaction.
        i_enable = 1'b1;
        randomize_settings();
        start_frame();
        repeat (2800) @(negedge clk);
        check("rst_mid_cs_low", o_cs, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_cs", o_cs, 1);
        check("rst_mid_sck", o_sck, 0);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_row", o_row_select, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        check("rst_mid_idle", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
